digit_scan_sequencer: RTL and testbench
=======================================

# digit_scan_sequencer

Upstream feeder for the 16-bit shift-register serializer in the seven-segment display path. It snapshots a packed multi-digit hex value and decodes each digit to segments. It then emits one 16-bit frame per digit, `{segments, one-hot digit select}`, over a valid/ready handshake, and follows each digit frame with a blanking frame to suppress ghosting. Dwell and blank durations are cycle-counted parameters, so the same RTL runs in simulation with short values and on the 16 MHz board with long ones.

## Interface
Parameters:
- `NUM_DIGITS`, default 3: number of digits scanned; legal range 1..8.
- `DWELL_CYCLES`, default 4096: cycles a digit frame is held after acceptance; must be ≥1.
- `BLANK_CYCLES`, default 256: cycles the blank frame is held after acceptance; 0 skips the blank wait.

Ports:
- `i_clk`, input, 1: system clock; single clock domain.
- `i_reset`, input, 1: reset is synchronous and active-high.
- `i_value`, input, 4*NUM_DIGITS: packed hex digits; digit k = `i_value[4k+3:4k]`, digit 0 = least significant nibble.
- `i_ser_ready`, input, 1: serializer can accept a frame.
- `o_frame`, output, 16: `{seg[7:0], sel[7:0]}`. seg = `{dp,g,f,e,d,c,b,a}`, active-high, dp always 0. sel = one-hot of digit index; `sel[k]` is 0 for k ≥ NUM_DIGITS.
- `o_frame_valid`, output, 1: `o_frame` is offered to the serializer.
- `o_digit_index`, output, 3: index of the digit currently being scanned.
- `o_scan_done`, output, 1: one-cycle pulse when the last digit's blank period ends.

## Operation
- Decode table (hex→seg): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71.
- FSM states, all transitions on `i_clk`:
  - **S_LATCH**: for 1 cycle, register `o_frame` = `{decode(digit[idx]), onehot(idx)}`. When idx==0, snapshot all of `i_value` into an internal register first. All digits of one scan come from that snapshot; there is no tearing mid-scan. → S_SEND.
  - **S_SEND**: `o_frame_valid`=1. When `i_ser_ready`=1 the frame transfers and the next state is S_DWELL.
  - **S_DWELL**: `o_frame_valid`=0, `o_frame` unchanged; count DWELL_CYCLES cycles. Then set `o_frame`=16'h0000 and go to S_BLANK_SEND.
  - **S_BLANK_SEND**: `o_frame_valid`=1 with frame 0. On transfer, go to S_BLANK_WAIT, or straight to the advance step if BLANK_CYCLES=0.
  - **S_BLANK_WAIT**: count BLANK_CYCLES cycles, then advance.
  - **Advance**: if idx==NUM_DIGITS-1, set idx=0 and pulse `o_scan_done` on the same cycle S_LATCH is entered; otherwise idx+1. → S_LATCH.
- Handshake rules:
  - Once `o_frame_valid` is high, it stays high and `o_frame` stays stable until the transfer cycle (valid & ready).
  - `i_ser_ready` is ignored while valid is low.
  - The cycle after a transfer always has valid=0; frames are never transferred back-to-back.
- Counters are sized `$clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1)` bits. They reload to 0 on entry to each wait state and never wrap.
- Changes to `i_value` mid-scan take effect only at the next idx==0 S_LATCH.

## Timing
- Reset values: `o_frame`=16'h0000, `o_frame_valid`=0, `o_digit_index`=0, `o_scan_done`=0, snapshot=0, state=S_LATCH.
- First cycle after `i_reset` falls: S_LATCH. The second cycle has `o_frame_valid`=1 with digit 0.
- With `i_ser_ready` held high:
  - digit frame valid for exactly 1 cycle;
  - blank frame valid at cycle 2+DWELL_CYCLES relative to the S_LATCH cycle;
  - digit period = 4+DWELL_CYCLES+BLANK_CYCLES cycles, or 3+DWELL_CYCLES when BLANK_CYCLES=0.
- `i_ser_ready` low stretches S_SEND and S_BLANK_SEND indefinitely; counters do not run while waiting.
- `i_reset` asserted in any state overrides everything on the next edge and drops valid immediately, even mid-handshake.
- NUM_DIGITS=1: idx stays 0, and `o_scan_done` pulses every digit period.

## Test plan
- **Basic scan.** NUM_DIGITS=3, DWELL=4, BLANK=2, `i_value`=12'h3A7, ready=1 → transfers in order 16'h0701, 0000, 16'h7702, 0000, 16'h4F04, 0000, repeating. Period 10 cycles per digit; `o_scan_done` pulses every 30 cycles.
- **Backpressure.** Same setup, ready=0 for 5 cycles while the first frame is valid → `o_frame` held at 16'h0701 with valid=1 for 6 cycles, and the dwell starts only after the transfer.
- **Snapshot.** Change `i_value` from 12'h3A7 to 12'hFFF during digit 1 → digits 1 and 2 still send 16'h7702 and 16'h4F04. The next scan sends 16'h7101, 16'h7102, 16'h7104.
- **Reset mid-handshake.** Assert `i_reset` for 1 cycle while a blank frame is valid → the next cycle has valid=0, frame=0, index=0. Digit 0 is re-offered 2 cycles after reset deasserts.
- **BLANK_CYCLES=0, DWELL=1.** Ready=1 → digit period is 4 cycles and the blank frame is still transferred.
- **Full decode sweep.** NUM_DIGITS=1, `i_value` stepped 0..F at each `o_scan_done` → segment byte matches the decode table for every digit; sel byte = 8'h01.

Source files
------------

// File: rtl/digit_scan_sequencer.sv
// Scans a snapshot of packed hex digits, emitting {segments, digit select} frames
// over valid/ready, each followed by a blanking frame to suppress ghosting.
module digit_scan_sequencer #(
    parameter int NUM_DIGITS   = 3,
    parameter int DWELL_CYCLES = 4096,
    parameter int BLANK_CYCLES = 256
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic                    i_ser_ready,
    output logic [15:0]             o_frame,
    output logic                    o_frame_valid,
    output logic [2:0]              o_digit_index,
    output logic                    o_scan_done
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES);
    localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        S_LATCH,
        S_SEND,
        S_DWELL,
        S_BLANK_SEND,
        S_BLANK_WAIT
    } state_t;

    state_t                  state;
    logic [4*NUM_DIGITS-1:0] snapshot;
    logic [CW-1:0]           cnt;
    logic [3:0]              cur_nibble;
    logic [7:0]              cur_sel;
    logic                    last_digit;
    logic [2:0]              next_idx;

    function automatic logic [7:0] decode_hex(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            default: seg = 8'h71;
        endcase
        return seg;
    endfunction

    // Digit 0 reads i_value directly because the snapshot is taken on that same edge.
    always_comb begin
        cur_nibble = i_value[3:0];
        if (o_digit_index != 3'd0) begin
            for (int k = 1; k < NUM_DIGITS; k++) begin
                if (o_digit_index == 3'(k)) begin
                    cur_nibble = snapshot[4*k +: 4];
                end
            end
        end
        cur_sel    = 8'b0000_0001 << o_digit_index;
        last_digit = (o_digit_index == LAST_IDX);
        next_idx   = last_digit ? 3'd0 : o_digit_index + 3'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= S_LATCH;
            snapshot      <= '0;
            cnt           <= '0;
            o_frame       <= 16'h0000;
            o_frame_valid <= 1'b0;
            o_digit_index <= 3'd0;
            o_scan_done   <= 1'b0;
        end else begin
            o_scan_done <= 1'b0;
            case (state)
                S_LATCH: begin
                    if (o_digit_index == 3'd0) begin
                        snapshot <= i_value;
                    end
                    o_frame       <= {decode_hex(cur_nibble), cur_sel};
                    o_frame_valid <= 1'b1;
                    state         <= S_SEND;
                end
                S_SEND: begin
                    if (i_ser_ready) begin
                        o_frame_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (cnt == DWELL_LAST) begin
                        o_frame       <= 16'h0000;
                        o_frame_valid <= 1'b1;
                        state         <= S_BLANK_SEND;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_BLANK_SEND: begin
                    if (i_ser_ready) begin
                        o_frame_valid <= 1'b0;
                        cnt           <= '0;
                        if (BLANK_CYCLES == 0) begin
                            o_digit_index <= next_idx;
                            o_scan_done   <= last_digit;
                            state         <= S_LATCH;
                        end else begin
                            state <= S_BLANK_WAIT;
                        end
                    end
                end
                // The cycle after the blank count expires is the advance step.
                S_BLANK_WAIT: begin
                    if (cnt == BLANK_LAST) begin
                        o_digit_index <= next_idx;
                        o_scan_done   <= last_digit;
                        state         <= S_LATCH;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_LATCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// Directed bench for digit_scan_sequencer: three instances cover the normal scan,
// the zero-blank configuration and a single-digit decode sweep.
module tb_digit_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: NUM_DIGITS=3, DWELL=4, BLANK=2
    logic        a_reset = 1'b1;
    logic [11:0] a_value = 12'h3A7;
    logic        a_ready = 1'b1;
    logic [15:0] a_frame;
    logic        a_valid;
    logic [2:0]  a_idx;
    logic        a_done;

    // Instance B: NUM_DIGITS=3, DWELL=1, BLANK=0
    logic        b_reset = 1'b1;
    logic [11:0] b_value = 12'h5C2;
    logic        b_ready = 1'b1;
    logic [15:0] b_frame;
    logic        b_valid;
    logic [2:0]  b_idx;
    logic        b_done;

    // Instance C: NUM_DIGITS=1, DWELL=2, BLANK=1
    logic        c_reset = 1'b1;
    logic [3:0]  c_value = 4'h0;
    logic        c_ready = 1'b1;
    logic [15:0] c_frame;
    logic        c_valid;
    logic [2:0]  c_idx;
    logic        c_done;

    digit_scan_sequencer #(.NUM_DIGITS(3), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut_a (
        .i_clk(clk), .i_reset(a_reset), .i_value(a_value), .i_ser_ready(a_ready),
        .o_frame(a_frame), .o_frame_valid(a_valid), .o_digit_index(a_idx), .o_scan_done(a_done)
    );

    digit_scan_sequencer #(.NUM_DIGITS(3), .DWELL_CYCLES(1), .BLANK_CYCLES(0)) dut_b (
        .i_clk(clk), .i_reset(b_reset), .i_value(b_value), .i_ser_ready(b_ready),
        .o_frame(b_frame), .o_frame_valid(b_valid), .o_digit_index(b_idx), .o_scan_done(b_done)
    );

    digit_scan_sequencer #(.NUM_DIGITS(1), .DWELL_CYCLES(2), .BLANK_CYCLES(1)) dut_c (
        .i_clk(clk), .i_reset(c_reset), .i_value(c_value), .i_ser_ready(c_ready),
        .o_frame(c_frame), .o_frame_valid(c_valid), .o_digit_index(c_idx), .o_scan_done(c_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_reset = 1'b1;
        a_ready = 1'b1;
        a_value = 12'h3A7;
        tick();
        tick();
        n_checks++; if (a_frame !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_frame got %h expected 0000", a_frame); end
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b expected 0", a_valid); end
        n_checks++; if (a_idx !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_index got %0d expected 0", a_idx); end
        n_checks++; if (a_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b expected 0", a_done); end
        a_reset = 1'b0;
        tick();
        n_checks++; if (a_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL first_offer_valid got %b expected 1", a_valid); end
        n_checks++; if (a_frame !== 16'h0701) begin n_fail++; $display("[TB] FAIL first_offer_frame got %h expected 0701", a_frame); end
    endtask

    // Continues from cycle 1 (first S_SEND) left by test_reset; cycle 0 is S_LATCH of digit 0.
    task automatic test_basic_scan();
        logic [15:0] digit_frames [3];
        logic [15:0] exp_frame;
        int ph;
        int d;
        digit_frames = '{16'h0701, 16'h7702, 16'h4F04};
        for (int c = 1; c <= 65; c++) begin
            if (c > 1) tick();
            ph = c % 10;
            d  = (c / 10) % 3;
            exp_frame = (ph >= 1 && ph <= 5) ? digit_frames[d] : 16'h0000;
            n_checks++; if (a_valid !== (ph == 1 || ph == 6)) begin n_fail++; $display("[TB] FAIL basic_valid c=%0d got %b expected %b", c, a_valid, (ph == 1 || ph == 6)); end
            n_checks++; if (a_frame !== exp_frame) begin n_fail++; $display("[TB] FAIL basic_frame c=%0d got %h expected %h", c, a_frame, exp_frame); end
            n_checks++; if (a_idx !== 3'(d)) begin n_fail++; $display("[TB] FAIL basic_index c=%0d got %0d expected %0d", c, a_idx, d); end
            n_checks++; if (a_done !== (c % 30 == 0)) begin n_fail++; $display("[TB] FAIL basic_done c=%0d got %b expected %b", c, a_done, (c % 30 == 0)); end
        end
    endtask

    task automatic test_backpressure();
        logic        exp_valid;
        logic [15:0] exp_frame;
        a_reset = 1'b1;
        a_ready = 1'b0;
        tick();
        a_reset = 1'b0;
        tick();
        for (int c = 1; c <= 15; c++) begin
            if (c > 1) tick();
            exp_valid = (c <= 6) || (c >= 11 && c <= 14);
            exp_frame = (c <= 10) ? 16'h0701 : 16'h0000;
            n_checks++; if (a_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL bp_valid c=%0d got %b expected %b", c, a_valid, exp_valid); end
            n_checks++; if (a_frame !== exp_frame) begin n_fail++; $display("[TB] FAIL bp_frame c=%0d got %h expected %h", c, a_frame, exp_frame); end
            n_checks++; if (a_idx !== 3'd0) begin n_fail++; $display("[TB] FAIL bp_index c=%0d got %0d expected 0", c, a_idx); end
            a_ready = (c >= 6 && c < 11) || (c >= 14);
        end
        a_ready = 1'b1;
    endtask

    task automatic test_snapshot();
        logic [15:0] scan0 [3];
        logic [15:0] scan1 [3];
        logic [15:0] exp_frame;
        int d;
        scan0 = '{16'h0701, 16'h7702, 16'h4F04};
        scan1 = '{16'h7101, 16'h7102, 16'h7104};
        a_reset = 1'b1;
        a_ready = 1'b1;
        a_value = 12'h3A7;
        tick();
        a_reset = 1'b0;
        tick();
        for (int c = 1; c <= 51; c++) begin
            if (c > 1) tick();
            if (c % 10 == 1) begin
                d = (c / 10) % 3;
                exp_frame = (c < 30) ? scan0[d] : scan1[d];
                n_checks++; if (a_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL snap_valid c=%0d got %b expected 1", c, a_valid); end
                n_checks++; if (a_frame !== exp_frame) begin n_fail++; $display("[TB] FAIL snap_frame c=%0d got %h expected %h", c, a_frame, exp_frame); end
            end
            if (c == 12) a_value = 12'hFFF;
        end
        a_value = 12'h3A7;
    endtask

    task automatic test_reset_mid_handshake();
        a_reset = 1'b1;
        a_ready = 1'b1;
        tick();
        a_reset = 1'b0;
        tick();
        for (int c = 2; c <= 16; c++) tick();
        n_checks++; if (a_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_blank_valid got %b expected 1", a_valid); end
        n_checks++; if (a_idx !== 3'd1) begin n_fail++; $display("[TB] FAIL mid_blank_index got %0d expected 1", a_idx); end
        a_ready = 1'b0;
        a_reset = 1'b1;
        tick();
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_valid got %b expected 0", a_valid); end
        n_checks++; if (a_frame !== 16'h0000) begin n_fail++; $display("[TB] FAIL mid_reset_frame got %h expected 0000", a_frame); end
        n_checks++; if (a_idx !== 3'd0) begin n_fail++; $display("[TB] FAIL mid_reset_index got %0d expected 0", a_idx); end
        a_reset = 1'b0;
        a_ready = 1'b1;
        tick();
        n_checks++; if (a_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_reoffer_valid got %b expected 1", a_valid); end
        n_checks++; if (a_frame !== 16'h0701) begin n_fail++; $display("[TB] FAIL mid_reoffer_frame got %h expected 0701", a_frame); end
    endtask

    // 12'h5C2: digit0=2 (5B), digit1=C (39), digit2=5 (6D); period 4 cycles.
    task automatic test_blank_zero();
        logic [15:0] digit_frames [3];
        logic [15:0] exp_frame;
        int ph;
        int d;
        digit_frames = '{16'h5B01, 16'h3902, 16'h6D04};
        b_reset = 1'b1;
        tick();
        b_reset = 1'b0;
        tick();
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) tick();
            ph = c % 4;
            d  = (c / 4) % 3;
            exp_frame = (ph == 1 || ph == 2) ? digit_frames[d] : 16'h0000;
            n_checks++; if (b_valid !== (ph == 1 || ph == 3)) begin n_fail++; $display("[TB] FAIL b0_valid c=%0d got %b expected %b", c, b_valid, (ph == 1 || ph == 3)); end
            n_checks++; if (b_frame !== exp_frame) begin n_fail++; $display("[TB] FAIL b0_frame c=%0d got %h expected %h", c, b_frame, exp_frame); end
            n_checks++; if (b_idx !== 3'(d)) begin n_fail++; $display("[TB] FAIL b0_index c=%0d got %0d expected %0d", c, b_idx, d); end
            n_checks++; if (b_done !== (c % 12 == 0)) begin n_fail++; $display("[TB] FAIL b0_done c=%0d got %b expected %b", c, b_done, (c % 12 == 0)); end
        end
    endtask

    task automatic test_decode_sweep();
        logic [7:0]  seg_table [16];
        logic [15:0] exp_frame;
        int waited;
        seg_table = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
        c_reset = 1'b1;
        c_value = 4'h0;
        tick();
        c_reset = 1'b0;
        tick();
        for (int v = 0; v < 16; v++) begin
            exp_frame = {seg_table[v], 8'h01};
            n_checks++; if (c_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL sweep_valid v=%0d got %b expected 1", v, c_valid); end
            n_checks++; if (c_frame !== exp_frame) begin n_fail++; $display("[TB] FAIL sweep_frame v=%0d got %h expected %h", v, c_frame, exp_frame); end
            waited = 0;
            do begin
                tick();
                waited++;
            end while (c_done !== 1'b1 && waited < 20);
            n_checks++; if (waited != 6) begin n_fail++; $display("[TB] FAIL sweep_done_delay v=%0d got %0d expected 6", v, waited); end
            n_checks++; if (c_idx !== 3'd0) begin n_fail++; $display("[TB] FAIL sweep_index v=%0d got %0d expected 0", v, c_idx); end
            c_value = 4'(v + 1);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_backpressure();
        test_snapshot();
        test_reset_mid_handshake();
        test_blank_zero();
        test_decode_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
